// File: rtl/hs_issue_scheduler_if.sv
// Channel request, datapath issue/return and result bus of hs_issue_scheduler.
interface hs_issue_scheduler_if #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CH_W       = 2,
  parameter int unsigned DATA_WIDTH = 26,
  parameter int unsigned OUT_SIZE   = 14
);
  logic                           cfg_en;
  logic [NUM_CH-1:0]              ch_valid;
  logic [NUM_CH-1:0]              ch_last;
  logic [NUM_CH*DATA_WIDTH-1:0]   ch_data;
  logic [NUM_CH-1:0]              ch_ready;
  logic                           hs_en;
  logic [DATA_WIDTH-1:0]          hs_data;
  logic                           hs_out_valid;
  logic [OUT_SIZE-1:0]            hs_out_data;
  logic                           res_valid;
  logic [OUT_SIZE-1:0]            res_data;
  logic [CH_W-1:0]                res_ch;
  logic                           res_last;
  logic [NUM_CH-1:0]              ch_done;
  logic                           idle;
  logic                           err_orphan;

  modport master (
    output cfg_en, ch_valid, ch_last, ch_data, hs_out_valid, hs_out_data,
    input  ch_ready, hs_en, hs_data, res_valid, res_data, res_ch, res_last,
           ch_done, idle, err_orphan
  );

  modport slave (
    input  cfg_en, ch_valid, ch_last, ch_data, hs_out_valid, hs_out_data,
    output ch_ready, hs_en, hs_data, res_valid, res_data, res_ch, res_last,
           ch_done, idle, err_orphan
  );
endinterface

// File: rtl/hs_issue_scheduler.sv
// Round-robin issue of NUM_CH channels into one shared hardswish datapath, with an
// in-order tag FIFO steering results back. HS_SCHED_PERF_EN adds perf counters.
module hs_issue_scheduler #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CH_W       = 2,
  parameter int unsigned DATA_WIDTH = 26,
  parameter int unsigned OUT_SIZE   = 14,
  parameter int unsigned TAG_DEPTH  = 8
) (
  input  logic                clk,
  input  logic                rst,
  hs_issue_scheduler_if.slave bus
`ifdef HS_SCHED_PERF_EN
  ,
  input  logic [CH_W-1:0]     perf_sel,
  output logic [15:0]         perf_cnt,
  output logic [15:0]         perf_stall
`endif
);
  localparam int unsigned PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic            last;
  } tag_t;

  logic [CH_W-1:0]       rr_q, rr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  tag_t                  tag_mem_q [TAG_DEPTH];
  logic                  hs_en_q, hs_en_d;
  logic [DATA_WIDTH-1:0] hs_data_q, hs_data_d;
  logic                  res_valid_q, res_valid_d;
  logic [OUT_SIZE-1:0]   res_data_q, res_data_d;
  logic [CH_W-1:0]       res_ch_q, res_ch_d;
  logic                  res_last_q, res_last_d;
  logic [NUM_CH-1:0]     ch_done_q, ch_done_d;
  logic                  idle_q, idle_d;
  logic                  err_q, err_d;

  logic [NUM_CH-1:0]     grant_c;
  logic [CH_W-1:0]       gnt_id_c, idx_c;
  logic                  gnt_found_c;
  logic                  tag_full_c, tag_empty_c, can_issue_c;
  logic                  push_c, pop_c;
  tag_t                  head_c;

  // First valid channel at or after the round-robin pointer, wrapping.
  always_comb begin
    grant_c     = '0;
    gnt_id_c    = '0;
    gnt_found_c = 1'b0;
    idx_c       = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      idx_c = CH_W'((32'(rr_q) + 32'(k)) % NUM_CH);
      if (!gnt_found_c && bus.ch_valid[idx_c]) begin
        gnt_found_c     = 1'b1;
        gnt_id_c        = idx_c;
        grant_c[idx_c]  = 1'b1;
      end
    end
  end

  assign tag_full_c  = (cnt_q == CNT_W'(TAG_DEPTH));
  assign tag_empty_c = (cnt_q == '0);
  assign can_issue_c = bus.cfg_en & ~tag_full_c & ~rst;
  assign bus.ch_ready = can_issue_c ? grant_c : '0;
  assign push_c      = can_issue_c & gnt_found_c;
  assign pop_c       = bus.hs_out_valid & ~tag_empty_c;
  assign head_c      = tag_mem_q[rd_ptr_q];

  always_comb begin
    rr_d        = rr_q;
    wr_ptr_d    = wr_ptr_q + PTR_W'(push_c);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop_c);
    cnt_d       = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
    hs_en_d     = push_c;
    hs_data_d   = hs_data_q;
    res_valid_d = pop_c;
    res_data_d  = res_data_q;
    res_ch_d    = res_ch_q;
    res_last_d  = res_last_q;
    ch_done_d   = '0;
    err_d       = err_q | (bus.hs_out_valid & tag_empty_c);
    if (push_c) begin
      rr_d      = (gnt_id_c == CH_W'(NUM_CH - 1)) ? '0 : gnt_id_c + CH_W'(1);
      hs_data_d = bus.ch_data[32'(gnt_id_c)*DATA_WIDTH +: DATA_WIDTH];
    end
    if (pop_c) begin
      res_data_d = bus.hs_out_data;
      res_ch_d   = head_c.ch;
      res_last_d = head_c.last;
      ch_done_d[head_c.ch] = head_c.last;
    end
    idle_d = (cnt_d == '0) & ~hs_en_d & ~res_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      hs_en_q     <= 1'b0;
      hs_data_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ch_q    <= '0;
      res_last_q  <= 1'b0;
      ch_done_q   <= '0;
      idle_q      <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      hs_en_q     <= hs_en_d;
      hs_data_q   <= hs_data_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_ch_q    <= res_ch_d;
      res_last_q  <= res_last_d;
      ch_done_q   <= ch_done_d;
      idle_q      <= idle_d;
      err_q       <= err_d;
    end
  end

  // Tag storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push_c) tag_mem_q[wr_ptr_q] <= '{ch: gnt_id_c, last: bus.ch_last[gnt_id_c]};
  end

  assign bus.hs_en      = hs_en_q;
  assign bus.hs_data    = hs_data_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_ch     = res_ch_q;
  assign bus.res_last   = res_last_q;
  assign bus.ch_done    = ch_done_q;
  assign bus.idle       = idle_q;
  assign bus.err_orphan = err_q;

`ifdef HS_SCHED_PERF_EN
  logic [15:0] perf_cnt_q [NUM_CH];
  logic [15:0] perf_cnt_d [NUM_CH];
  logic [15:0] perf_stall_q, perf_stall_d;

  // Stall = some channel wants to issue but cfg_en or a full tag FIFO blocks it.
  always_comb begin
    perf_cnt_d   = perf_cnt_q;
    perf_stall_d = perf_stall_q;
    if (push_c) perf_cnt_d[gnt_id_c] = perf_cnt_q[gnt_id_c] + 16'd1;
    if ((|bus.ch_valid) && !can_issue_c) perf_stall_d = perf_stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_CH); i++) perf_cnt_q[i] <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_cnt_q   <= perf_cnt_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_cnt   = (32'(perf_sel) < NUM_CH) ? perf_cnt_q[perf_sel] : '0;
  assign perf_stall = perf_stall_q;
`endif
endmodule

// File: tb/tb_hs_issue_scheduler.sv
// Randomized self-checking bench for hs_issue_scheduler with a latency-5 datapath model.
module tb_hs_issue_scheduler;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;
  localparam int unsigned DW     = 26;
  localparam int unsigned OS     = 14;
  localparam int unsigned DEPTH  = 8;

  typedef struct packed {
    logic              hs_en;
    logic [DW-1:0]     hs_data;
    logic              res_valid;
    logic [OS-1:0]     res_data;
    logic [CH_W-1:0]   res_ch;
    logic              res_last;
    logic [NUM_CH-1:0] done;
    logic              idle;
    logic              err;
  } obs_t;

  typedef struct { logic [DW-1:0] d; int rdy; } dp_t;
  typedef struct { int ch; bit last; logic [DW-1:0] d; } mtag_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  hs_issue_scheduler_if #(.NUM_CH(NUM_CH), .CH_W(CH_W), .DATA_WIDTH(DW), .OUT_SIZE(OS)) bus ();

`ifdef HS_SCHED_PERF_EN
  logic [CH_W-1:0] perf_sel = '0;
  logic [15:0]     perf_cnt, perf_stall;
`endif

  hs_issue_scheduler #(.NUM_CH(NUM_CH), .CH_W(CH_W), .DATA_WIDTH(DW), .OUT_SIZE(OS),
                       .TAG_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
`ifdef HS_SCHED_PERF_EN
    , .perf_sel(perf_sel), .perf_cnt(perf_cnt), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int   n_vec = 0, n_err = 0, cyc = 0;
  bit   dp_stall = 1'b0;
  int   dp_rel_req = 0, dp_rel_done = 0;
  dp_t  dp_q[$];
  mtag_t mq[$];
  int   rr = 0;
  obs_t cur, nxt, rst_obs;
  logic [NUM_CH-1:0] e_ready;

  always @(posedge clk) cyc++;

  function automatic logic [OS-1:0] dp_f(input logic [DW-1:0] d);
    return OS'(d >> 3) ^ 14'h1a5c;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o = '{hs_en: bus.hs_en, hs_data: bus.hs_data, res_valid: bus.res_valid,
          res_data: bus.res_data, res_ch: bus.res_ch, res_last: bus.res_last,
          done: bus.ch_done, idle: bus.idle, err: bus.err_orphan};
    return o;
  endfunction

  // Datapath stand-in plus scheduler reference: in-order queue, round-robin search.
  always @(negedge clk) begin
    mtag_t t;
    int g;
    if (dp_q.size() > 0 && dp_q[0].rdy <= cyc && (!dp_stall || dp_rel_req > dp_rel_done)) begin
      if (dp_stall) dp_rel_done++;
      bus.hs_out_valid = 1'b1;
      bus.hs_out_data  = dp_f(dp_q[0].d);
      void'(dp_q.pop_front());
    end else begin
      bus.hs_out_valid = 1'b0;
    end
    if (bus.hs_en === 1'b1) dp_q.push_back('{d: bus.hs_data, rdy: cyc + 5});

    cur     = nxt;
    e_ready = '0;
    g       = -1;
    if (rst) begin
      mq.delete();
      rr       = 0;
      nxt      = '0;
      nxt.idle = 1'b1;
    end else begin
      if (bus.cfg_en && mq.size() < int'(DEPTH))
        for (int k = 0; k < int'(NUM_CH); k++)
          if (g < 0 && bus.ch_valid[(rr + k) % NUM_CH]) g = (rr + k) % NUM_CH;
      nxt.res_valid = 1'b0;
      nxt.done      = '0;
      if (bus.hs_out_valid) begin
        if (mq.size() > 0) begin
          t = mq.pop_front();
          nxt.res_valid = 1'b1;
          nxt.res_data  = dp_f(t.d);
          nxt.res_ch    = CH_W'(t.ch);
          nxt.res_last  = t.last;
          if (t.last) nxt.done = NUM_CH'(1) << t.ch;
        end else begin
          nxt.err = 1'b1;
        end
      end
      if (g >= 0) begin
        e_ready     = NUM_CH'(1) << g;
        nxt.hs_en   = 1'b1;
        nxt.hs_data = bus.ch_data[g*DW +: DW];
        mq.push_back('{ch: g, last: bus.ch_last[g], d: bus.ch_data[g*DW +: DW]});
        rr = (g + 1) % NUM_CH;
      end else begin
        nxt.hs_en = 1'b0;
      end
      nxt.idle = (mq.size() == 0) && !nxt.hs_en && !nxt.res_valid;
    end
  end

  task automatic drv_edge(); @(posedge clk); #1; endtask
  task automatic chk_edge(); @(negedge clk); #1; endtask

  task automatic test_reset();
    rst = 1'b1; bus.cfg_en = 1'b1; bus.ch_valid = '1;
    repeat (3) begin
      chk_edge();
      n_vec++;
      if (bus.ch_ready !== '0) begin
        n_err++; $display("FAIL reset_ready: got %b want 0", bus.ch_ready);
      end
      n_vec++;
      if (dut_obs() !== rst_obs) begin
        n_err++; $display("FAIL reset_state: got %h want %h", dut_obs(), rst_obs);
      end
      drv_edge();
    end
    rst = 1'b0; bus.ch_valid = '0;
  endtask

  task automatic test_single();
    int lat;
    bus.cfg_en = 1'b1; bus.ch_valid = 4'b0001; bus.ch_last = '0;
    bus.ch_data = '0; bus.ch_data[0 +: DW] = 26'h0000200;
    chk_edge();
    n_vec++;
    if (bus.ch_ready !== 4'b0001) begin
      n_err++; $display("FAIL single_grant: got %b want 0001", bus.ch_ready);
    end
    drv_edge(); bus.ch_valid = '0;
    chk_edge();
    n_vec++;
    if (bus.hs_en !== 1'b1 || bus.hs_data !== 26'h200) begin
      n_err++; $display("FAIL single_issue: got en=%b data=%h want en=1 data=200", bus.hs_en, bus.hs_data);
    end
    lat = 1;
    while (bus.res_valid !== 1'b1 && lat < 20) begin drv_edge(); chk_edge(); lat++; end
    n_vec++;
    if (lat != 7 || bus.res_ch !== 2'd0 || bus.res_data !== 14'h1a1c || bus.res_last !== 1'b0) begin
      n_err++; $display("FAIL single_result: got lat=%0d ch=%0d data=%h last=%b want lat=7 ch=0 data=1a1c last=0",
                        lat, bus.res_ch, bus.res_data, bus.res_last);
    end
    drv_edge(); chk_edge();
    n_vec++;
    if (bus.idle !== 1'b1) begin n_err++; $display("FAIL single_idle: got %b want 1", bus.idle); end
    drv_edge();
  endtask

  task automatic test_rotate();
    int nres = 0, first = -1, last = -1;
    for (int i = 0; i < 28; i++) begin
      bus.ch_valid = (i < 16) ? '1 : '0;
      for (int c = 0; c < int'(NUM_CH); c++) bus.ch_data[c*DW +: DW] = DW'($urandom);
      chk_edge();
      if (i < 16) begin
        n_vec++;
        if (bus.ch_ready !== (NUM_CH'(1) << ((1 + i) % NUM_CH))) begin
          n_err++; $display("FAIL rotate_grant[%0d]: got %b want %b", i, bus.ch_ready, NUM_CH'(1) << ((1 + i) % NUM_CH));
        end
      end
      n_vec++;
      if (dut_obs() !== cur) begin
        n_err++; $display("FAIL rotate_out[%0d]: got %h want %h", i, dut_obs(), cur);
      end
      if (bus.res_valid === 1'b1) begin nres++; if (first < 0) first = i; last = i; end
      drv_edge();
    end
    n_vec++;
    if (nres != 16 || last - first + 1 != 16) begin
      n_err++; $display("FAIL rotate_count: got %0d results over %0d cycles want 16 over 16", nres, last - first + 1);
    end
  endtask

  task automatic test_stall();
    int issued = 0;
    dp_stall = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.ch_valid = '1;
      for (int c = 0; c < int'(NUM_CH); c++) bus.ch_data[c*DW +: DW] = DW'($urandom);
      chk_edge();
      n_vec++;
      if (bus.ch_ready !== e_ready) begin
        n_err++; $display("FAIL stall_grant[%0d]: got %b want %b", i, bus.ch_ready, e_ready);
      end
      if ((bus.ch_valid & bus.ch_ready) != '0) issued++;
      drv_edge();
    end
    n_vec++;
    if (issued != int'(DEPTH)) begin n_err++; $display("FAIL stall_issues: got %0d want 8", issued); end
    dp_rel_req++;
    for (int i = 0; i < 3; i++) begin
      chk_edge();
      n_vec++;
      if ($countones(bus.ch_ready) != ((i == 1) ? 1 : 0)) begin
        n_err++; $display("FAIL stall_release[%0d]: got %b want %0d grant(s)", i, bus.ch_ready, (i == 1) ? 1 : 0);
      end
      drv_edge();
    end
    dp_stall = 1'b0; bus.ch_valid = '0;
    for (int i = 0; i < 20; i++) begin
      chk_edge();
      n_vec++;
      if (dut_obs() !== cur) begin n_err++; $display("FAIL stall_drain[%0d]: got %h want %h", i, dut_obs(), cur); end
      drv_edge();
    end
  endtask

  task automatic test_last();
    int sent = 0, ndone = 0, nres = 0;
    for (int i = 0; i < 20; i++) begin
      bus.ch_valid = (sent < 3) ? 4'b0100 : '0;
      bus.ch_last  = (sent == 2) ? 4'b0100 : '0;
      bus.ch_data[2*DW +: DW] = DW'($urandom);
      chk_edge();
      n_vec++;
      if (bus.ch_ready !== e_ready || dut_obs() !== cur) begin
        n_err++; $display("FAIL last_step[%0d]: got rdy=%b out=%h want rdy=%b out=%h", i, bus.ch_ready, dut_obs(), e_ready, cur);
      end
      if (bus.ch_ready[2] === 1'b1 && bus.ch_valid[2]) sent++;
      if (bus.res_valid === 1'b1) nres++;
      if (bus.ch_done !== '0) begin
        ndone++;
        n_vec++;
        if (bus.ch_done !== 4'b0100 || bus.res_valid !== 1'b1 || bus.res_last !== 1'b1 || nres != 3) begin
          n_err++; $display("FAIL last_done: got done=%b rv=%b rl=%b nres=%0d want 0100 1 1 3",
                            bus.ch_done, bus.res_valid, bus.res_last, nres);
        end
      end
      drv_edge();
    end
    bus.ch_last = '0;
    n_vec++;
    if (ndone != 1 || nres != 3) begin n_err++; $display("FAIL last_count: got done=%0d res=%0d want 1 3", ndone, nres); end
  endtask

  task automatic test_cfg();
    int sent = 0, nres = 0, guard = 0;
    bit idle_seen = 1'b0;
    bus.cfg_en = 1'b1; bus.ch_valid = 4'b0010;
    while (sent < 3 && guard < 20) begin
      bus.ch_data[1*DW +: DW] = DW'($urandom);
      chk_edge();
      if (bus.ch_ready[1] === 1'b1) sent++;
      guard++;
      drv_edge();
    end
    bus.cfg_en = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk_edge();
      n_vec++;
      if (bus.ch_ready !== '0 || dut_obs() !== cur) begin
        n_err++; $display("FAIL cfg_step[%0d]: got rdy=%b out=%h want rdy=0 out=%h", i, bus.ch_ready, dut_obs(), cur);
      end
      if (nres == 3 && !idle_seen) begin
        idle_seen = 1'b1;
        n_vec++;
        if (bus.idle !== 1'b1) begin n_err++; $display("FAIL cfg_idle: got %b want 1", bus.idle); end
      end
      if (bus.res_valid === 1'b1) nres++;
      drv_edge();
    end
    n_vec++;
    if (nres != 3 || !idle_seen) begin n_err++; $display("FAIL cfg_count: got %0d results want 3", nres); end
    bus.cfg_en = 1'b1; bus.ch_valid = '0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 330; i++) begin
      if (i < 300) begin
        bus.ch_valid = NUM_CH'($urandom);
        bus.ch_last  = NUM_CH'($urandom);
        for (int c = 0; c < int'(NUM_CH); c++) bus.ch_data[c*DW +: DW] = DW'($urandom);
        bus.cfg_en = ($urandom_range(0, 9) != 0);
        dp_stall   = ($urandom_range(0, 2) == 0);
      end else begin
        bus.ch_valid = '0; bus.cfg_en = 1'b1; dp_stall = 1'b0;
      end
      chk_edge();
      n_vec++;
      if (bus.ch_ready !== e_ready || dut_obs() !== cur) begin
        n_err++; $display("FAIL random[%0d]: got rdy=%b out=%h want rdy=%b out=%h", i, bus.ch_ready, dut_obs(), e_ready, cur);
      end
      drv_edge();
    end
    bus.ch_last = '0;
    chk_edge();
    n_vec++;
    if (bus.idle !== 1'b1) begin n_err++; $display("FAIL random_idle: got %b want 1", bus.idle); end
    drv_edge();
  endtask

  task automatic test_reset_mid();
    int sent = 0, guard = 0;
    for (int i = 0; i < 4; i++) begin
      bus.ch_valid = '1;
      for (int c = 0; c < int'(NUM_CH); c++) bus.ch_data[c*DW +: DW] = DW'($urandom);
      chk_edge();
      if ((bus.ch_valid & bus.ch_ready) != '0) sent++;
      drv_edge();
    end
    bus.ch_valid = '0; rst = 1'b1;
    chk_edge();
    n_vec++;
    if (sent != 4 || bus.ch_ready !== '0) begin
      n_err++; $display("FAIL mid_setup: got sent=%0d rdy=%b want 4 0", sent, bus.ch_ready);
    end
    drv_edge(); rst = 1'b0;
    chk_edge();
    n_vec++;
    if (dut_obs() !== rst_obs) begin n_err++; $display("FAIL mid_reset: got %h want %h", dut_obs(), rst_obs); end
    while (bus.hs_out_valid !== 1'b1 && guard < 20) begin drv_edge(); chk_edge(); guard++; end
    n_vec++;
    if (guard >= 20) begin n_err++; $display("FAIL mid_late: got no late result want one within 20 cycles"); end
    for (int i = 0; i < 6; i++) begin
      drv_edge(); chk_edge();
      n_vec++;
      if (bus.err_orphan !== 1'b1 || bus.res_valid !== 1'b0 || dut_obs() !== cur) begin
        n_err++; $display("FAIL mid_orphan[%0d]: got err=%b rv=%b out=%h want err=1 rv=0 out=%h",
                          i, bus.err_orphan, bus.res_valid, dut_obs(), cur);
      end
    end
  endtask

  initial begin
    rst_obs = '0; rst_obs.idle = 1'b1;
    nxt = rst_obs; cur = rst_obs; e_ready = '0;
    bus.cfg_en = 1'b0; bus.ch_valid = '0; bus.ch_last = '0; bus.ch_data = '0;
    bus.hs_out_valid = 1'b0; bus.hs_out_data = '0;
    test_reset();
    test_single();
    test_rotate();
    test_stall();
    test_last();
    test_cfg();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish before 200000");
    $fatal(1);
  end
endmodule
